// File: rtl/core_fetch.sv
// core_fetch: instruction prefetcher, one read in flight, FIFO_DEPTH-entry queue of {insn, hptr}.
// Latency: insn_valid rises 1 cycle after mem_ready; 1 insn per 2 cycles with a 1-cycle memory.
// Backpressure: fetch_stall holds the head; no read issues once queued + in-flight reach FIFO_DEPTH.
module core_fetch #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        branch,
   input  logic [30:0] target,
   input  logic        fetch_stall,
   input  logic        mem_ready,
   input  logic [31:0] mem_data,
   output logic        mem_start,
   output logic [29:0] mem_addr,
   output logic        insn_valid,
   output logic [31:0] insn,
   output logic [30:0] insn_pc
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] CNT_MAX = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,   // nothing outstanding
      S_WAIT = 2'd1,   // read outstanding, response will be queued
      S_DROP = 2'd2    // read outstanding, response will be discarded
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [30:0]   r_fpc;
   logic [30:0]   r_ipc;
   logic [31:0]   r_qdat [FIFO_DEPTH];
   logic [30:0]   r_qpc  [FIFO_DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [AW:0]   r_count;
   logic          w_issue;
   logic          w_push;
   logic          w_pop;

   assign w_pop      = (r_count != '0) && !fetch_stall;
   assign mem_start  = w_issue && rst_n;
   assign mem_addr   = r_fpc[30:1];
   assign insn_valid = (r_count != '0);
   assign insn       = r_qdat[r_head];
   assign insn_pc    = r_qpc[r_head];

   // Next state, issue and push decisions; branch suppresses issue and push.
   // A response that lands in the same cycle as a branch completes the read,
   // so the FSM returns to RUN rather than waiting in DROP for a reply that
   // will never come.
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_push      = 1'b0;
      case (r_state)
         S_RUN: begin
            if (!branch && (r_count < CNT_MAX)) begin
               w_issue     = 1'b1;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_ready) begin
               w_push      = !branch;
               w_state_nxt = S_RUN;
            end else if (branch) begin
               w_state_nxt = S_DROP;
            end
         end
         S_DROP: begin
            if (mem_ready) begin
               w_state_nxt = S_RUN;
            end
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   // Control state: FSM, fetch pointer, queue pointers; branch flushes and redirects.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RUN;
         r_fpc   <= '0;
         r_ipc   <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (branch) begin
            r_fpc   <= target & 31'h7FFF_FFFE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_issue) begin
               r_ipc <= r_fpc;
               r_fpc <= r_fpc + 31'd2;
            end
            if (w_push) begin
               r_tail <= r_tail + AW'(1);
            end
            if (w_pop) begin
               r_head <= r_head + AW'(1);
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + (AW+1)'(1);
               2'b01:   r_count <= r_count - (AW+1)'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Queue storage; contents are don't-care outside the valid window, so no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_qdat[r_tail] <= mem_data;
         r_qpc[r_tail]  <= r_ipc;
      end
   end

endmodule

// File: tb/tb_core_fetch.sv
// tb_core_fetch: directed scenarios plus random traffic against a queue-based reference model.
// Latency: driver sets inputs at negedge, checks at +1, monitor pops at +2, model updates at +3.
// Backpressure: fetch_stall randomised; bench memory answers only outstanding reads (plus stray pulses).
module tb_core_fetch;

   localparam int DEPTH = 2;

   logic        clk;
   logic        rst_n;
   logic        branch;
   logic [30:0] target;
   logic        fetch_stall;
   logic        mem_ready;
   logic [31:0] mem_data;
   logic        mem_start;
   logic [29:0] mem_addr;
   logic        insn_valid;
   logic [31:0] insn;
   logic [30:0] insn_pc;

   core_fetch #(.FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .branch      (branch),
      .target      (target),
      .fetch_stall (fetch_stall),
      .mem_ready   (mem_ready),
      .mem_data    (mem_data),
      .mem_start   (mem_start),
      .mem_addr    (mem_addr),
      .insn_valid  (insn_valid),
      .insn        (insn),
      .insn_pc     (insn_pc)
   );

   typedef struct {
      logic [31:0] dat;
      logic [30:0] pc;
   } ent_t;

   // Reference model: expected queue contents, fetch pointer, in-flight read.
   ent_t        exp_q[$];
   logic [30:0] m_fpc;
   logic [30:0] m_ipc;
   bit          m_out;
   bit          m_keep;

   int n_chk;
   int n_pass;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_fpc  = '0;
      m_ipc  = '0;
      m_out  = 0;
      m_keep = 0;
   endtask

   // One clock cycle of stimulus with cycle-exact checks and model update.
   task automatic cycle(input logic br, input logic [30:0] tg, input logic st,
                        input logic rd, input logic [31:0] dt);
      bit iss;
      @(negedge clk);
      branch = br; target = tg; fetch_stall = st; mem_ready = rd; mem_data = dt;
      #1;
      iss = !br && !m_out && (exp_q.size() < DEPTH);
      chk("mem_start", 64'(mem_start), 64'(iss));
      if (iss) chk("mem_addr", 64'(mem_addr), 64'(m_fpc[30:1]));
      chk("insn_valid", 64'(insn_valid), 64'(exp_q.size() != 0));
      #2;
      if (m_out && rd) begin
         if (m_keep && !br) exp_q.push_back('{dat: dt, pc: m_ipc});
         m_out = 0;
      end else if (m_out && br) begin
         m_keep = 0;
      end
      if (br) begin
         exp_q.delete();
         m_fpc = {tg[30:1], 1'b0};
      end
      if (iss) begin
         m_ipc  = m_fpc;
         m_fpc  = m_fpc + 31'd2;
         m_out  = 1;
         m_keep = 1;
      end
   endtask

   // Memory answers the outstanding read immediately with random data.
   task automatic run(input int n, input logic st);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, st, logic'(m_out), $urandom);
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst_n = 1'b0; branch = 1'b0; fetch_stall = 1'b0; mem_ready = 1'b0;
      #1;
      chk("rst_mem_start", 64'(mem_start), 64'd0);
      chk("rst_insn_valid", 64'(insn_valid), 64'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   // Scoreboard monitor: compare every consumed head against the expected queue.
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && insn_valid && !fetch_stall && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("insn", 64'(insn), 64'(e.dat));
            chk("insn_pc", 64'(insn_pc), 64'(e.pc));
         end
      end
   end

   initial begin
      n_chk = 0; n_pass = 0;
      rst_n = 1'b0; branch = 1'b0; target = '0; fetch_stall = 1'b0;
      mem_ready = 1'b0; mem_data = '0;
      model_reset();
      #1;
      chk("por_mem_start", 64'(mem_start), 64'd0);
      chk("por_insn_valid", 64'(insn_valid), 64'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Two back-to-back fetches from 0 with one-cycle memory.
      cycle(1'b0, '0, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, '0, 1'b0, 1'b1, 32'h1111_1111);
      cycle(1'b0, '0, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, '0, 1'b0, 1'b1, 32'h2222_2222);
      cycle(1'b0, '0, 1'b0, 1'b0, 32'h0);
      chk("seq_fpc_after_two", 64'(m_fpc), 64'd6);

      // Stall holds the queue: only DEPTH reads issue, then resume.
      reset_pulse();
      run(8, 1'b1);
      chk("stall_queue_full", 64'(exp_q.size()), 64'(DEPTH));
      run(10, 1'b0);

      // Branch while the read at addr 5 is outstanding.
      reset_pulse();
      cycle(1'b1, 31'd10, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, '0, 1'b0, 1'b0, 32'h0);
      cycle(1'b1, 31'h40, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      run(6, 1'b0);

      // Full queue popping in the same cycle as a branch.
      reset_pulse();
      run(6, 1'b1);
      cycle(1'b1, 31'h10, 1'b0, 1'b0, 32'h0);
      run(6, 1'b0);

      // Redirect to the top of the address space, then wrap.
      cycle(1'b1, 31'h7FFF_FFFF, 1'b0, 1'b0, 32'h0);
      chk("top_fpc", 64'(m_fpc), 64'h7FFF_FFFE);
      run(6, 1'b0);

      // Reset mid-WAIT, then a stale response arrives after release.
      reset_pulse();
      cycle(1'b0, '0, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, '0, 1'b0, 1'b0, 32'h0);
      reset_pulse();
      cycle(1'b0, '0, 1'b0, 1'b1, 32'hBAD0_BAD0);
      run(6, 1'b0);

      // Reset-vector redirect: branch to 0 straight out of reset.
      reset_pulse();
      cycle(1'b1, '0, 1'b0, 1'b0, 32'h0);
      run(4, 1'b0);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         logic        br, st, rd;
         logic [30:0] tg;
         if ($urandom_range(0, 199) == 0) reset_pulse();
         br = ($urandom_range(0, 99) < 6);
         tg = ($urandom_range(0, 9) == 0) ? 31'h7FFF_FFFF : 31'($urandom);
         st = ($urandom_range(0, 99) < 30);
         rd = m_out ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 10);
         cycle(br, tg, st, rd, $urandom);
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/core_fetch.md
CORE_FETCH -- requirements
Module: core_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning prefetch queue entries; legal values are 2 or 4.
REQ-002 SHALL have port clk  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port branch  input  1  redirect request from the branch unit; 1-cycle pulse or level.
REQ-005 SHALL have port target  input  31  redirect halfword pointer (hptr); bit 0 ignored.
REQ-006 SHALL have port fetch_stall  input  1  decode cannot accept the head entry this cycle.
REQ-007 SHALL have port mem_ready  input  1  instruction memory returns read data this cycle.
REQ-008 SHALL have port mem_data  input  32  instruction word returned with mem_ready.
REQ-009 SHALL have port mem_start  output  1  1-cycle pulse issuing a read.
REQ-010 SHALL have port mem_addr  output  30  word address of the read issued with mem_start.
REQ-011 SHALL have port insn_valid  output  1  queue head is valid.
REQ-012 SHALL have port insn  output  32  queue-head instruction word.
REQ-013 SHALL have port insn_pc  output  31  queue-head hptr, bit 0 always 0.

Function
REQ-014 SHALL hold a fetch pointer fpc (31 bits, bit 0 = 0); each issued read uses mem_addr = fpc[30:1], then fpc += 2 (wraps modulo 2^31).
REQ-015 SHALL keep at most one read outstanding; mem_start SHALL NOT assert while a read is outstanding.
REQ-016 SHALL use states RUN (no read outstanding), WAIT (read outstanding, response kept) and DROP (read outstanding, response discarded).
REQ-017 In RUN, with no branch and the queue count plus in-flight reads below FIFO_DEPTH, SHALL assert mem_start and go to WAIT in the same cycle.
REQ-018 In WAIT, mem_ready SHALL push {mem_data, issue pc} to the queue tail and return to RUN; issue in the same cycle is not required.
REQ-019 Head pop SHALL occur when insn_valid && !fetch_stall; push and pop in the same cycle SHALL be legal when the queue is full.
REQ-020 When branch=1 in any state: queue SHALL flush (insn_valid=0 next cycle); fpc SHALL load {target[30:1],1'b0}; WAIT SHALL go to DROP; DROP stays DROP; RUN stays RUN.
REQ-021 A branch SHALL take priority over a same-cycle push and pop; no entry pushed in that cycle survives.
REQ-022 In DROP, mem_ready SHALL discard mem_data, push nothing and go to RUN.
REQ-023 While branch=1, mem_start SHALL be 0; the first read after a redirect SHALL issue in the cycle after branch deasserts, at the redirected fpc.
REQ-024 insn and insn_pc SHALL be don't-care when insn_valid=0.
REQ-025 mem_ready in RUN SHALL be ignored.
REQ-026 Latency: with memory replying the cycle after mem_start and fetch_stall=0, SHALL sustain one instruction per 2 cycles; insn_valid SHALL rise 1 cycle after mem_ready.

Reset
REQ-027 On rst_n=0, SHALL immediately set state=RUN, fpc=0, queue empty, insn_valid=0 and mem_start=0, regardless of any read outstanding.
REQ-028 A mem_ready arriving after reset for a pre-reset read SHALL be ignored (state RUN, per REQ-025).
REQ-029 First mem_start after reset release SHALL carry mem_addr=0 unless branch is asserted, in which case REQ-023 applies; the branch unit's reset vector (branch=1, target=0) SHALL yield the same address 0.

Verification
REQ-030 Reset release, memory returns 0x11111111 then 0x22222222 one cycle after each mem_start, fetch_stall=0 -> insn/insn_pc pairs (0x11111111,0), (0x22222222,2), mem_addr 0,1.
REQ-031 fetch_stall held 1, FIFO_DEPTH=2 -> exactly 2 reads issued (addr 0,1), then mem_start stays 0; release stall -> pops in order, fetch resumes at addr 2.
REQ-032 Read at addr 5 outstanding, branch=1 with target=0x40 -> that response dropped, queue empty, next mem_addr=0x20, next insn_pc=0x40.
REQ-033 Queue full and head popping in the same cycle as branch=1 with target=0x10 -> insn_valid=0 next cycle; the next entry pushed has insn_pc=0x10.
REQ-034 target=0x7FFFFFFF -> mem_addr=0x3FFFFFFF, insn_pc=0x7FFFFFFE; following fetch wraps to mem_addr=0.
REQ-035 rst_n pulsed low while in WAIT, late mem_ready after release -> no entry pushed; first mem_addr after release=0.
